// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the PIC10-compatible core: PC, IR, 2-level return stack, Q1..Q4 phasing.
// Optional SLEEP support is compiled in with `define CPU_SLEEP_EN; without it SLEEP is a NOP.
module cpu_control_unit #(
  parameter int PC_WIDTH = 9,
  parameter int SFR_TOP  = 7,
  parameter int PCL_ADDR = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         prog_data_in,
  input  logic [7:0]          alu_result_in,
  input  logic                wake_in,
  output logic [PC_WIDTH-1:0] prog_addr_out,
  output logic [11:0]         instruction_out,
  output logic [4:0]          reg_addr_out,
  output logic                alu_in_select,
  output logic                store_alu_w,
  output logic                reg_write_en,
  output logic                commit_out,
  output logic [1:0]          q_phase_out
);

  typedef enum logic [2:0] {
    ST_Q1    = 3'd0,
    ST_Q2    = 3'd1,
    ST_Q3    = 3'd2,
    ST_Q4    = 3'd3,
    ST_SLEEP = 3'd4
  } state_t;

  localparam logic [11:0] NOP_WORD   = 12'h000;
  localparam logic [4:0]  SFR_TOP_A  = 5'(SFR_TOP);
  localparam logic [4:0]  PCL_ADDR_A = 5'(PCL_ADDR);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic [PC_WIDTH-1:0]   stack0_q, stack0_d, stack1_q, stack1_d;
  logic [11:0]           ir_q, ir_d;
  logic                  flush_q, flush_d;

  logic is_byte_op, is_movwf, is_clrw, is_clrf, is_bit_sc, is_bit_test;
  logic is_fsz, is_retlw, is_call, is_goto, is_literal, is_file_op;
  logic d_bit, commit, pcl_write, skip_taken;

  // Opcode decode of the current IR.
  assign is_byte_op  = (ir_q[11:10] == 2'b00) && (ir_q[9:6] >= 4'b0010);
  assign is_movwf    = (ir_q[11:5] == 7'b0000001);
  assign is_clrw     = (ir_q[11:5] == 7'b0000010);
  assign is_clrf     = (ir_q[11:5] == 7'b0000011);
  assign is_bit_sc   = (ir_q[11:9] == 3'b010);
  assign is_bit_test = (ir_q[11:9] == 3'b011);
  assign is_fsz      = (ir_q[11:9] == 3'b001) && (ir_q[7:6] == 2'b11);
  assign is_retlw    = (ir_q[11:8] == 4'b1000);
  assign is_call     = (ir_q[11:8] == 4'b1001);
  assign is_goto     = (ir_q[11:9] == 3'b101);
  assign is_literal  = (ir_q[11:10] == 2'b11);
  assign is_file_op  = is_byte_op | is_movwf | is_clrf | is_bit_sc | is_bit_test;
  assign d_bit       = ir_q[5];

  // A flushed NOP reaches Q4 like any other word but never commits.
  assign commit       = (state_q == ST_Q4) && !flush_q;
  assign store_alu_w  = commit && ((is_byte_op && !d_bit) || is_literal || is_retlw || is_clrw);
  assign reg_write_en = commit && ((is_byte_op && d_bit) || is_movwf || is_clrf || is_bit_sc);
  assign pcl_write    = reg_write_en && (ir_q[4:0] == PCL_ADDR_A);
  assign skip_taken   = (is_fsz && (alu_result_in == 8'h00)) ||
                        (is_bit_test && (alu_result_in[ir_q[7:5]] == ir_q[8]));

  assign pc_inc          = pc_q + PC_WIDTH'(1);
  assign prog_addr_out   = pc_q;
  assign instruction_out = ir_q;
  assign reg_addr_out    = ir_q[4:0];
  assign alu_in_select   = is_file_op && (ir_q[4:0] <= SFR_TOP_A);
  assign commit_out      = commit;
  assign q_phase_out     = (state_q == ST_SLEEP) ? 2'd0 : state_q[1:0];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flush_d  = flush_q;
    stack0_d = stack0_q;
    stack1_d = stack1_q;
    case (state_q)
      ST_Q1: state_d = ST_Q2;
      ST_Q2: state_d = ST_Q3;
      ST_Q3: state_d = ST_Q4;
      ST_Q4: begin
        state_d = ST_Q1;
        ir_d    = prog_data_in;
        flush_d = 1'b0;
        pc_d    = pc_inc;
        if (commit) begin
          if (is_goto) begin
            pc_d    = PC_WIDTH'(ir_q[8:0]);
            ir_d    = NOP_WORD;
            flush_d = 1'b1;
          end else if (is_call) begin
            // Two-deep stack: the oldest return address falls off on a third push.
            stack1_d = stack0_q;
            stack0_d = pc_q;
            pc_d     = PC_WIDTH'(ir_q[7:0]);
            ir_d     = NOP_WORD;
            flush_d  = 1'b1;
          end else if (is_retlw) begin
            pc_d     = stack0_q;
            stack0_d = stack1_q;
            ir_d     = NOP_WORD;
            flush_d  = 1'b1;
          end else if (pcl_write) begin
            pc_d    = PC_WIDTH'(alu_result_in);
            ir_d    = NOP_WORD;
            flush_d = 1'b1;
          end else if (skip_taken) begin
            ir_d    = NOP_WORD;
            flush_d = 1'b1;
          end
`ifdef CPU_SLEEP_EN
          else if (ir_q == 12'h003) begin
            state_d = ST_SLEEP;
          end
`endif
        end
      end
      ST_SLEEP: begin
`ifdef CPU_SLEEP_EN
        if (wake_in) state_d = ST_Q1;
`else
        state_d = ST_Q1;
`endif
      end
      default: state_d = ST_Q1;
    endcase
  end

`ifndef CPU_SLEEP_EN
  logic unused_wake;
  assign unused_wake = wake_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_Q1;
    else     state_q <= state_d;
  end

  // NOTE: the return stack is two plain flops, so it is reset explicitly like the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '1;
      ir_q     <= NOP_WORD;
      flush_q  <= 1'b1;
      stack0_q <= '0;
      stack1_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flush_q  <= flush_d;
      stack0_q <= stack0_d;
      stack1_q <= stack1_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: reset, GOTO/CALL/RETLW, skips, PCL writes and SLEEP.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] prog_data_in;
  logic [7:0]  alu_result_in = 8'h00;
  logic        wake_in = 1'b0;
  logic [8:0]  prog_addr_out;
  logic [11:0] instruction_out;
  logic [4:0]  reg_addr_out;
  logic        alu_in_select, store_alu_w, reg_write_en, commit_out;
  logic [1:0]  q_phase_out;

  logic [11:0] mem [0:511];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;
  assign prog_data_in = mem[prog_addr_out];

  cpu_control_unit dut (
    .clk             (clk),
    .rst             (rst),
    .prog_data_in    (prog_data_in),
    .alu_result_in   (alu_result_in),
    .wake_in         (wake_in),
    .prog_addr_out   (prog_addr_out),
    .instruction_out (instruction_out),
    .reg_addr_out    (reg_addr_out),
    .alu_in_select   (alu_in_select),
    .store_alu_w     (store_alu_w),
    .reg_write_en    (reg_write_en),
    .commit_out      (commit_out),
    .q_phase_out     (q_phase_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 12'h000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // From Q1: advance to Q4, sample strobes, then advance to the next Q1.
  task automatic run_cycle(output logic c, output logic w, output logic r, output logic [1:0] ph);
    repeat (3) tick();
    c  = commit_out;
    w  = store_alu_w;
    r  = reg_write_en;
    ph = q_phase_out;
    tick();
  endtask

  task automatic exec_check(input string tag, input logic ec, input logic ew, input logic er);
    logic c, w, r;
    logic [1:0] ph;
    run_cycle(c, w, r, ph);
    check({tag, ".commit"}, 32'(c), 32'(ec));
    check({tag, ".store_w"}, 32'(w), 32'(ew));
    check({tag, ".reg_wr"}, 32'(r), 32'(er));
  endtask

  task automatic skip_cycle();
    logic c, w, r;
    logic [1:0] ph;
    run_cycle(c, w, r, ph);
  endtask

  task automatic check_fetch(input string tag, input logic [8:0] addr, input logic [11:0] ir);
    check({tag, ".addr"}, 32'(prog_addr_out), 32'(addr));
    check({tag, ".ir"}, 32'(instruction_out), 32'(ir));
  endtask

  initial begin
    logic c, w, r;
    logic [1:0] ph;
    logic hold_ok;

    // Reset, GOTO and the three-deep CALL/RETLW chain.
    clear_mem();
    mem[9'h1FF] = 12'hAA5;
    mem[9'h0A5] = 12'hA00;
    mem[9'h000] = 12'h910;
    mem[9'h010] = 12'h920;
    mem[9'h020] = 12'h930;
    mem[9'h030] = 12'h855;
    mem[9'h021] = 12'h866;
    mem[9'h011] = 12'h877;
    do_reset();
    check_fetch("reset", 9'h1FF, 12'h000);
    check("reset.phase", 32'(q_phase_out), 0);
    run_cycle(c, w, r, ph);
    check("reset_nop.q4phase", 32'(ph), 3);
    check("reset_nop.store_w", 32'(w), 0);
    check("reset_nop.reg_wr", 32'(r), 0);
    check_fetch("first_fetch", 9'h000, 12'hAA5);
    exec_check("goto", 1'b1, 1'b0, 1'b0);
    check_fetch("goto_target", 9'h0A5, 12'h000);
    exec_check("goto_flush", 1'b0, 1'b0, 1'b0);
    check_fetch("after_goto", 9'h0A6, 12'hA00);
    skip_cycle();
    skip_cycle();
    check_fetch("call1", 9'h001, 12'h910);
    skip_cycle();
    skip_cycle();
    check_fetch("call2", 9'h011, 12'h920);
    skip_cycle();
    skip_cycle();
    check_fetch("call3", 9'h021, 12'h930);
    skip_cycle();
    skip_cycle();
    check_fetch("retlw1_fetch", 9'h031, 12'h855);
    exec_check("retlw1", 1'b1, 1'b1, 1'b0);
    check("retlw1.ret", 32'(prog_addr_out), 'h021);
    skip_cycle();
    check("retlw2.ir", 32'(instruction_out), 'h866);
    skip_cycle();
    check("retlw2.ret", 32'(prog_addr_out), 'h011);
    skip_cycle();
    check("retlw3.ir", 32'(instruction_out), 'h877);
    skip_cycle();
    check("retlw3.ret_underflow", 32'(prog_addr_out), 'h011);
    // Reset asserted mid-cycle.
    tick();
    check("midrst.pre_phase", 32'(q_phase_out), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_fetch("midrst", 9'h1FF, 12'h000);
    check("midrst.phase", 32'(q_phase_out), 0);

    // DECFSZ / BTFSS / BTFSC skips and CLRF.
    clear_mem();
    mem[9'h1FF] = 12'h2F0;
    mem[9'h000] = 12'hC12;
    mem[9'h001] = 12'h2F0;
    mem[9'h002] = 12'hC34;
    mem[9'h003] = 12'h743;
    mem[9'h004] = 12'hC56;
    mem[9'h005] = 12'h643;
    mem[9'h006] = 12'h065;
    do_reset();
    skip_cycle();
    check("decfsz.sfr_sel", 32'(alu_in_select), 0);
    alu_result_in = 8'h00;
    exec_check("decfsz_skip", 1'b1, 1'b0, 1'b1);
    check_fetch("skip_nop", 9'h001, 12'h000);
    exec_check("skipped", 1'b0, 1'b0, 1'b0);
    check_fetch("decfsz2", 9'h002, 12'h2F0);
    alu_result_in = 8'h05;
    exec_check("decfsz_noskip", 1'b1, 1'b0, 1'b1);
    check_fetch("movlw", 9'h003, 12'hC34);
    exec_check("movlw", 1'b1, 1'b1, 1'b0);
    check("btfss.sfr_sel", 32'(alu_in_select), 1);
    alu_result_in = 8'h04;
    exec_check("btfss_skip", 1'b1, 1'b0, 1'b0);
    check_fetch("btfss_nop", 9'h005, 12'h000);
    skip_cycle();
    check_fetch("btfsc", 9'h006, 12'h643);
    exec_check("btfsc_noskip", 1'b1, 1'b0, 1'b0);
    check_fetch("clrf", 9'h007, 12'h065);
    exec_check("clrf", 1'b1, 1'b0, 1'b1);

    // MOVWF to PCL, CLRW, unused opcode.
    clear_mem();
    mem[9'h1FF] = 12'h022;
    mem[9'h040] = 12'h040;
    mem[9'h041] = 12'h002;
    do_reset();
    skip_cycle();
    alu_result_in = 8'h40;
    exec_check("movwf_pcl", 1'b1, 1'b0, 1'b1);
    check_fetch("pcl_target", 9'h040, 12'h000);
    exec_check("pcl_flush", 1'b0, 1'b0, 1'b0);
    check_fetch("clrw", 9'h041, 12'h040);
    alu_result_in = 8'h00;
    exec_check("clrw", 1'b1, 1'b1, 1'b0);
    check("option.ir", 32'(instruction_out), 'h002);
    exec_check("option", 1'b1, 1'b0, 1'b0);

    // SLEEP.
    clear_mem();
    mem[9'h1FF] = 12'h003;
    mem[9'h000] = 12'hC12;
    mem[9'h001] = 12'hC13;
    do_reset();
    skip_cycle();
    check("sleep.ir", 32'(instruction_out), 'h003);
    exec_check("sleep", 1'b1, 1'b0, 1'b0);
    check_fetch("sleep_after", 9'h001, 12'hC12);
    check("sleep_after.phase", 32'(q_phase_out), 0);
`ifdef CPU_SLEEP_EN
    hold_ok = 1'b1;
    repeat (20) begin
      tick();
      if (prog_addr_out !== 9'h001 || q_phase_out !== 2'd0 || commit_out !== 1'b0 ||
          store_alu_w !== 1'b0 || instruction_out !== 12'hC12) hold_ok = 1'b0;
    end
    check("sleep_hold", 32'(hold_ok), 1);
    wake_in = 1'b1;
    tick();
    wake_in = 1'b0;
`else
    hold_ok = 1'b1;
    wake_in = 1'b1;
`endif
    exec_check("wake_movlw", 1'b1, 1'b1, 1'b0);
    wake_in = 1'b0;
    check_fetch("wake_next", 9'h002, 12'hC13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
